// File: rtl/virtio_mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package virtio_mem_arbiter_pkg;

  // Arbiter sequencing: grant in IDLE, pulse memory in ISSUE, wait for completion in WAIT.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/virtio_mem_arbiter_slot.sv
// Per-port request slot: holds one captured request until the arbiter completes it.
// Latency: capture on the pulse edge; cur_* show the incoming pulse combinationally when empty.
// Backpressure: none; a pulse while full is dropped and sets the sticky overrun flag.
// Ports: clk/rst; request_enable/mode/addr/wdata/wstrb from the master; clear from the
//        arbiter on completion; candidate, cur_* (latched or incoming fields), overrun.
module mem_req_slot #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                request_enable,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                clear,
  output logic                candidate,
  output logic                cur_mode,
  output logic [ADDR_W-1:0]   cur_addr,
  output logic [DATA_W-1:0]   cur_wdata,
  output logic [DATA_W/8-1:0] cur_wstrb,
  output logic                overrun
);
  import virtio_mem_arbiter_pkg::*;

  localparam int STRB_W = DATA_W / 8;

  logic              pending;
  logic              mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      mode_q  <= MODE_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      overrun <= 1'b0;
    end else begin
      // A pulse arriving in the completion cycle still sees pending=1 and is dropped.
      if (request_enable && pending) begin
        overrun <= 1'b1;
      end
      if (request_enable && !pending) begin
        pending <= 1'b1;
        mode_q  <= mode;
        addr_q  <= addr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

  // The arbiter may grant in the same cycle as the pulse, before the latch is loaded.
  assign candidate = pending | request_enable;
  assign cur_mode  = pending ? mode_q  : mode;
  assign cur_addr  = pending ? addr_q  : addr;
  assign cur_wdata = pending ? wdata_q : wdata;
  assign cur_wstrb = pending ? wstrb_q : wstrb;

endmodule

// File: rtl/virtio_mem_arbiter.sv
// Shares one single-outstanding memory port between the core (port 0) and virtio DMA (port 1).
// Latency: request pulse n -> mem_request_enable n+1; mem_response_enable m -> port pulse m+1.
// Backpressure: one request held per port; extra pulses are dropped and flagged in pN_overrun.
// Ports: clk, rst (async, active high); pN_request_enable/mode/addr/wdata/wstrb in,
//        pN_response_enable/data/overrun out (N=0,1); mem_request_enable/mode/addr/wdata/wstrb
//        out, mem_response_enable/data in; busy out (high whenever not IDLE).
module virtio_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_request_enable,
  input  logic                p0_mode,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wstrb,
  output logic                p0_response_enable,
  output logic [DATA_W-1:0]   p0_data,
  output logic                p0_overrun,
  input  logic                p1_request_enable,
  input  logic                p1_mode,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wstrb,
  output logic                p1_response_enable,
  output logic [DATA_W-1:0]   p1_data,
  output logic                p1_overrun,
  output logic                mem_request_enable,
  output logic                mem_mode,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_response_enable,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                busy
);
  import virtio_mem_arbiter_pkg::*;

  localparam int STRB_W = DATA_W / 8;

  state_t state, state_nxt;
  logic   grant;       // port owning the current memory transaction
  logic   rr_ptr;      // port preferred on the next tie
  logic   sel;         // port chosen this cycle if a grant fires
  logic   issue_fire;
  logic   rsp_fire;

  logic              cand0, cand1;
  logic              s0_mode, s1_mode;
  logic [ADDR_W-1:0] s0_addr, s1_addr;
  logic [DATA_W-1:0] s0_wdata, s1_wdata;
  logic [STRB_W-1:0] s0_wstrb, s1_wstrb;

  mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk            (clk),
    .rst            (rst),
    .request_enable (p0_request_enable),
    .mode           (p0_mode),
    .addr           (p0_addr),
    .wdata          (p0_wdata),
    .wstrb          (p0_wstrb),
    .clear          (rsp_fire && !grant),
    .candidate      (cand0),
    .cur_mode       (s0_mode),
    .cur_addr       (s0_addr),
    .cur_wdata      (s0_wdata),
    .cur_wstrb      (s0_wstrb),
    .overrun        (p0_overrun)
  );

  mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk            (clk),
    .rst            (rst),
    .request_enable (p1_request_enable),
    .mode           (p1_mode),
    .addr           (p1_addr),
    .wdata          (p1_wdata),
    .wstrb          (p1_wstrb),
    .clear          (rsp_fire && grant),
    .candidate      (cand1),
    .cur_mode       (s1_mode),
    .cur_addr       (s1_addr),
    .cur_wdata      (s1_wdata),
    .cur_wstrb      (s1_wstrb),
    .overrun        (p1_overrun)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    issue_fire = 1'b0;
    rsp_fire   = 1'b0;
    // A lone candidate wins outright; ties go to port 0 or the round-robin pointer.
    sel        = cand1;
    if (cand0 && cand1) begin
      sel = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
    end
    case (state)
      ST_IDLE: begin
        if (cand0 || cand1) begin
          issue_fire = 1'b1;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Responses outside WAIT are spurious and never reach this branch.
        if (mem_response_enable) begin
          rsp_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant              <= 1'b0;
      rr_ptr             <= 1'b0;
      mem_request_enable <= 1'b0;
      mem_mode           <= MODE_READ;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      mem_wstrb          <= '0;
      p0_response_enable <= 1'b0;
      p1_response_enable <= 1'b0;
      p0_data            <= '0;
      p1_data            <= '0;
    end else begin
      // Registering the grant makes the memory pulse coincide with the ISSUE state.
      mem_request_enable <= issue_fire;
      p0_response_enable <= rsp_fire && !grant;
      p1_response_enable <= rsp_fire && grant;
      if (issue_fire) begin
        grant     <= sel;
        mem_mode  <= sel ? s1_mode  : s0_mode;
        mem_addr  <= sel ? s1_addr  : s0_addr;
        mem_wdata <= sel ? s1_wdata : s0_wdata;
        mem_wstrb <= sel ? s1_wstrb : s0_wstrb;
      end
      if (rsp_fire) begin
        rr_ptr <= ~grant;
        if (grant) begin
          p1_data <= mem_data;
        end else begin
          p0_data <= mem_data;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_virtio_mem_arbiter.sv
// Bench: two arbiters (round-robin and fixed priority) share the request stimulus; each has
// its own memory responder. A transaction-level model predicts memory requests and port
// responses into queues; a negedge monitor pops and compares when the DUTs pulse.
module tb_virtio_mem_arbiter;
  import virtio_mem_arbiter_pkg::*;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;
  typedef struct { req_t r; int cyc; } exp_mem_t;
  typedef struct { int port; logic [31:0] data; int cyc; } exp_rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        p_req [2];
  logic        p_mode [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_wstrb [2];
  logic        m_rsp [2];
  logic [31:0] m_rdata [2];

  logic        o_rsp0 [2], o_rsp1 [2], o_ovr0 [2], o_ovr1 [2];
  logic        o_mreq [2], o_mmode [2], o_busy [2];
  logic [31:0] o_d0 [2], o_d1 [2], o_maddr [2], o_mwdata [2];
  logic [3:0]  o_mwstrb [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    virtio_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(k)) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .p0_request_enable   (p_req[0]),
      .p0_mode             (p_mode[0]),
      .p0_addr             (p_addr[0]),
      .p0_wdata            (p_wdata[0]),
      .p0_wstrb            (p_wstrb[0]),
      .p0_response_enable  (o_rsp0[k]),
      .p0_data             (o_d0[k]),
      .p0_overrun          (o_ovr0[k]),
      .p1_request_enable   (p_req[1]),
      .p1_mode             (p_mode[1]),
      .p1_addr             (p_addr[1]),
      .p1_wdata            (p_wdata[1]),
      .p1_wstrb            (p_wstrb[1]),
      .p1_response_enable  (o_rsp1[k]),
      .p1_data             (o_d1[k]),
      .p1_overrun          (o_ovr1[k]),
      .mem_request_enable  (o_mreq[k]),
      .mem_mode            (o_mmode[k]),
      .mem_addr            (o_maddr[k]),
      .mem_wdata           (o_mwdata[k]),
      .mem_wstrb           (o_mwstrb[k]),
      .mem_response_enable (m_rsp[k]),
      .mem_data            (m_rdata[k]),
      .busy                (o_busy[k])
    );
  end

  // ---------------- reference model state ----------------
  bit          mpend [2][2];
  bit          mover [2][2];
  req_t        mreq [2][2];
  logic [31:0] mlast [2][2];
  bit          mrr [2];
  int          mgrant [2];
  int          free_at [2], rsp_at [2], busy_from [2], busy_to [2];
  logic [31:0] rdata_pend [2];
  int          fixed_delay = 0;
  bit          use_fixed_rdata = 0;
  logic [31:0] fixed_rdata = '0;

  exp_mem_t mq0 [$], mq1 [$];
  exp_rsp_t rq0 [$], rq1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic mode, input logic [31:0] addr);
    req_t r;
    r.mode  = mode;
    r.addr  = addr;
    r.wdata = $urandom();
    r.wstrb = 4'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic bit active(input int k);
    return rsp_at[k] >= 0 || mpend[k][0] || mpend[k][1];
  endfunction

  task automatic model_reset(input int k, input int t);
    for (int p = 0; p < 2; p++) begin
      mpend[k][p] = 1'b0;
      mover[k][p] = 1'b0;
      mlast[k][p] = '0;
      mreq[k][p]  = '0;
    end
    mrr[k]       = 1'b0;
    mgrant[k]    = 0;
    free_at[k]   = t;
    rsp_at[k]    = -1;
    busy_from[k] = 0;
    busy_to[k]   = -1;
  endtask

  // ---------------- monitor ----------------
  task automatic mon_mem(input int k);
    exp_mem_t e;
    bit have = 1'b0;
    if (k == 0 && mq0.size() > 0) begin e = mq0.pop_front(); have = 1'b1; end
    else if (k == 1 && mq1.size() > 0) begin e = mq1.pop_front(); have = 1'b1; end
    check($sformatf("u%0d mem_req expected", k), have, 1'b1);
    if (have) begin
      check($sformatf("u%0d mem_req cycle", k), cyc, e.cyc);
      check($sformatf("u%0d mem_mode", k), o_mmode[k], e.r.mode);
      check($sformatf("u%0d mem_addr", k), o_maddr[k], e.r.addr);
      check($sformatf("u%0d mem_wdata", k), o_mwdata[k], e.r.wdata);
      check($sformatf("u%0d mem_wstrb", k), o_mwstrb[k], e.r.wstrb);
    end
  endtask

  task automatic mon_rsp(input int k, input int port, input logic [31:0] data);
    exp_rsp_t e;
    bit have = 1'b0;
    if (k == 0 && rq0.size() > 0) begin e = rq0.pop_front(); have = 1'b1; end
    else if (k == 1 && rq1.size() > 0) begin e = rq1.pop_front(); have = 1'b1; end
    check($sformatf("u%0d p%0d response expected", k, port), have, 1'b1);
    if (have) begin
      check($sformatf("u%0d response port", k), port, e.port);
      check($sformatf("u%0d response cycle", k), cyc, e.cyc);
      check($sformatf("u%0d p%0d_data", k, port), data, e.data);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_mreq[k]) mon_mem(k);
      if (o_rsp0[k]) mon_rsp(k, 0, o_d0[k]);
      if (o_rsp1[k]) mon_rsp(k, 1, o_d1[k]);
    end
  end

  // ---------------- driver + model, one cycle per call ----------------
  task automatic step(input bit r0, input req_t a0, input bit r1, input req_t a1,
                      input bit spur, input bit rs);
    int t, g, gr;
    bit real_rsp, c0, c1, rq;
    req_t f;
    exp_mem_t em;
    exp_rsp_t er;
    @(posedge clk);
    #1;
    t = cyc;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d busy", k), o_busy[k], (t >= busy_from[k] && t <= busy_to[k]));
      check($sformatf("u%0d p0_overrun", k), o_ovr0[k], mover[k][0]);
      check($sformatf("u%0d p1_overrun", k), o_ovr1[k], mover[k][1]);
      check($sformatf("u%0d p0_data hold", k), o_d0[k], mlast[k][0]);
      check($sformatf("u%0d p1_data hold", k), o_d1[k], mlast[k][1]);
    end
    rst        = rs;
    p_req[0]   = r0 && !rs;
    p_mode[0]  = a0.mode;
    p_addr[0]  = a0.addr;
    p_wdata[0] = a0.wdata;
    p_wstrb[0] = a0.wstrb;
    p_req[1]   = r1 && !rs;
    p_mode[1]  = a1.mode;
    p_addr[1]  = a1.addr;
    p_wdata[1] = a1.wdata;
    p_wstrb[1] = a1.wstrb;
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_rsp[k] = 1'b0;
        model_reset(k, t + 1);
      end else begin
        real_rsp   = (rsp_at[k] == t);
        m_rsp[k]   = real_rsp || (spur && rsp_at[k] < 0);
        m_rdata[k] = real_rsp ? rdata_pend[k] : $urandom();
        gr = mgrant[k];
        if (real_rsp) begin
          er.port = gr; er.data = rdata_pend[k]; er.cyc = t + 1;
          if (k == 0) rq0.push_back(er); else rq1.push_back(er);
          mlast[k][gr] = rdata_pend[k];
          mrr[k]       = (gr == 0);
          free_at[k]   = t + 1;
          rsp_at[k]    = -1;
        end
        if (t >= free_at[k]) begin
          c0 = mpend[k][0] || r0;
          c1 = mpend[k][1] || r1;
          if (c0 || c1) begin
            if (c0 && c1) g = (k == 1) ? 0 : int'(mrr[k]);
            else g = c1 ? 1 : 0;
            if (mpend[k][g]) f = mreq[k][g];
            else f = (g == 0) ? a0 : a1;
            em.r = f; em.cyc = t + 1;
            if (k == 0) mq0.push_back(em); else mq1.push_back(em);
            mgrant[k]     = g;
            busy_from[k]  = t + 1;
            rsp_at[k]     = t + 1 + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4)));
            busy_to[k]    = rsp_at[k];
            free_at[k]    = 1 << 30;
            rdata_pend[k] = use_fixed_rdata ? fixed_rdata : $urandom();
          end
        end
        for (int p = 0; p < 2; p++) begin
          rq = (p == 0) ? r0 : r1;
          if (rq) begin
            if (mpend[k][p]) mover[k][p] = 1'b1;
            else begin
              mpend[k][p] = 1'b1;
              mreq[k][p]  = (p == 0) ? a0 : a1;
            end
          end
        end
        if (real_rsp) mpend[k][gr] = 1'b0;
      end
    end
  endtask

  task automatic idle(input bit spur);
    step(1'b0, '0, 1'b0, '0, spur, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (n < 200 && (active(0) || active(1))) begin
      idle(1'b0);
      n++;
    end
    check("drain finished", active(0) || active(1), 1'b0);
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic check_zero();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d rst busy", k), o_busy[k], 1'b0);
      check($sformatf("u%0d rst mem_request_enable", k), o_mreq[k], 1'b0);
      check($sformatf("u%0d rst mem_mode", k), o_mmode[k], 1'b0);
      check($sformatf("u%0d rst mem_addr", k), o_maddr[k], 32'h0);
      check($sformatf("u%0d rst mem_wdata", k), o_mwdata[k], 32'h0);
      check($sformatf("u%0d rst mem_wstrb", k), o_mwstrb[k], 4'h0);
      check($sformatf("u%0d rst p0_response_enable", k), o_rsp0[k], 1'b0);
      check($sformatf("u%0d rst p1_response_enable", k), o_rsp1[k], 1'b0);
      check($sformatf("u%0d rst p0_data", k), o_d0[k], 32'h0);
      check($sformatf("u%0d rst p1_data", k), o_d1[k], 32'h0);
      check($sformatf("u%0d rst p0_overrun", k), o_ovr0[k], 1'b0);
      check($sformatf("u%0d rst p1_overrun", k), o_ovr1[k], 1'b0);
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_mode[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; p_wstrb[p] = '0;
      m_rsp[p] = 1'b0; m_rdata[p] = '0;
      model_reset(p, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    idle(1'b0);

    // Single read, memory answers 3 cycles after the issue pulse.
    fixed_delay = 3; use_fixed_rdata = 1'b1; fixed_rdata = 32'hDEADBEEF;
    step(1'b1, mk(MODE_READ, 32'h8000_1000), 1'b0, '0, 1'b0, 1'b0);
    drain();
    use_fixed_rdata = 1'b0; fixed_delay = 0;

    // Tie after reset, then a lone p0 to move the pointer, then the same tie again.
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, mk(MODE_WRITE, 32'h100), 1'b1, mk(MODE_READ, 32'h200), 1'b0, 1'b0);
    drain();
    step(1'b1, mk(MODE_READ, 32'h180), 1'b0, '0, 1'b0, 1'b0);
    drain();
    step(1'b1, mk(MODE_WRITE, 32'h100), 1'b1, mk(MODE_READ, 32'h200), 1'b0, 1'b0);
    drain();

    // Overrun: two further p1 pulses while its first request is outstanding.
    step(1'b0, '0, 1'b1, mk(MODE_READ, 32'h300), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, mk(MODE_WRITE, 32'h340), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, mk(MODE_WRITE, 32'h380), 1'b0, 1'b0);
    drain();

    // Spurious memory responses while idle.
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // p1 re-requests as soon as it is free; p0 requests once mid-stream.
    for (int i = 0; i < 40; i++) begin
      step(i == 9, mk(MODE_WRITE, 32'h500), !mpend[1][1],
           mk(MODE_READ, 32'h600 + 32'(i * 4)), 1'b0, 1'b0);
    end
    drain();

    // Reset during WAIT, then a late memory response, then normal service.
    fixed_delay = 4;
    step(1'b1, mk(MODE_READ, 32'h700), 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    #1;
    check_zero();
    idle(1'b1);
    idle(1'b0);
    fixed_delay = 0;
    step(1'b1, mk(MODE_WRITE, 32'h744), 1'b0, '0, 1'b0, 1'b0);
    drain();

    // Random traffic with occasional spurious responses.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, mk(1'($urandom_range(0, 1)), $urandom()),
           $urandom_range(0, 3) == 0, mk(1'($urandom_range(0, 1)), $urandom()),
           $urandom_range(0, 7) == 0, 1'b0);
    end
    drain();

    check("u0 mem queue empty", mq0.size(), 0);
    check("u1 mem queue empty", mq1.size(), 0);
    check("u0 response queue empty", rq0.size(), 0);
    check("u1 response queue empty", rq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
